// File: rtl/ysyx_22040365_wbu_if.sv
// Writeback unit bus: retiring-instruction handshake, load-data return and
// register-file write port, bundled so the upstream side and the WBU share one view.
interface ysyx_22040365_wbu_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  in_rd_wen;
  logic                  in_is_load;
  logic [2:0]            in_funct3;
  logic [2:0]            in_addr_lo;
  logic [DATA_WIDTH-1:0] in_result;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  commit_valid;
  logic                  err;

  // Upstream pipeline / memory side.
  modport master (
    output in_valid, in_rd, in_rd_wen, in_is_load, in_funct3, in_addr_lo, in_result,
    output mem_rvalid, mem_rdata,
    input  in_ready, rf_wen, rf_waddr, rf_wdata, commit_valid, err
  );

  // Writeback unit side.
  modport slave (
    input  in_valid, in_rd, in_rd_wen, in_is_load, in_funct3, in_addr_lo, in_result,
    input  mem_rvalid, mem_rdata,
    output in_ready, rf_wen, rf_waddr, rf_wdata, commit_valid, err
  );
endinterface

// File: rtl/ysyx_22040365_wbu.sv
// Writeback unit: retires one instruction at a time, waits for and extends load data,
// and drives the register-file write port plus a one-cycle commit pulse.
module ysyx_22040365_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  ysyx_22040365_wbu_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WRITE
  } state_e;

  // Last WAIT_MEM count before the load is abandoned; reaching TIMEOUT means giving up.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic                  accept;
  logic                  rvalid_hit;
  logic                  timeout_hit;
  logic                  enter_write;

  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  rd_wen_q;
  logic [2:0]            funct3_q;
  logic [2:0]            addr_lo_q;
  logic [7:0]            cnt_q;

  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_bad;

  logic                  wen_d;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  err_set;

  logic                  rf_wen_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic                  commit_q;
  logic                  err_q;

  assign bus.in_ready = (state_q != WAIT_MEM);
  assign accept       = bus.in_valid && (state_q != WAIT_MEM);
  assign rvalid_hit   = (state_q == WAIT_MEM) && bus.mem_rvalid;
  // Data arriving on the final count wins over the timeout.
  assign timeout_hit  = (state_q == WAIT_MEM) && !bus.mem_rvalid && (cnt_q == CNT_LAST);
  assign enter_write  = (state_d == WRITE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, WRITE: begin
        if (accept) state_d = bus.in_is_load ? WAIT_MEM : WRITE;
        else        state_d = IDLE;
      end
      WAIT_MEM: if (rvalid_hit || timeout_hit) state_d = WRITE;
      default:  state_d = IDLE;
    endcase
  end

  // Load extraction: shift the addressed byte into lane 0, then size and extend.
  always_comb begin
    lane      = bus.mem_rdata >> {addr_lo_q, 3'b000};
    load_data = '0;
    load_bad  = 1'b0;
    case (funct3_q)
      3'b000:  load_data = {{(DATA_WIDTH-8){lane[7]}},   lane[7:0]};
      3'b001:  load_data = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      3'b010:  load_data = {{(DATA_WIDTH-32){lane[31]}}, lane[31:0]};
      3'b011:  load_data = lane;
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}},      lane[7:0]};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}},     lane[15:0]};
      3'b110:  load_data = {{(DATA_WIDTH-32){1'b0}},     lane[31:0]};
      default: load_bad  = 1'b1;
    endcase
  end

  // Values loaded into the write-port registers on the edge that enters WRITE.
  // Outside WAIT_MEM the only way into WRITE is a non-load accepted this cycle.
  always_comb begin
    wen_d   = 1'b0;
    waddr_d = rd_q;
    wdata_d = '0;
    err_set = 1'b0;
    if (state_q == WAIT_MEM) begin
      wen_d = rd_wen_q && (rd_q != '0);
      if (rvalid_hit) begin
        wdata_d = load_data;
        err_set = load_bad;
      end else if (timeout_hit) begin
        err_set = 1'b1;
      end
    end else begin
      wen_d   = bus.in_rd_wen && (bus.in_rd != '0);
      waddr_d = bus.in_rd;
      wdata_d = bus.in_result;
      err_set = bus.mem_rvalid;
    end
  end

  // NOTE: the latched instruction fields carry no reset; they are only read after
  // an accept has loaded them, so resetting them would add wiring with no effect.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_q      <= bus.in_rd;
      rd_wen_q  <= bus.in_rd_wen;
      funct3_q  <= bus.in_funct3;
      addr_lo_q <= bus.in_addr_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      commit_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      commit_q <= enter_write;
      rf_wen_q <= enter_write && wen_d;
      if (enter_write) begin
        rf_waddr_q <= waddr_d;
        rf_wdata_q <= wdata_d;
      end
      if (err_set) err_q <= 1'b1;
      if (accept)                     cnt_q <= '0;
      else if (state_q == WAIT_MEM)   cnt_q <= cnt_q + 8'd1;
    end
  end

  assign bus.rf_wen       = rf_wen_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.commit_valid = commit_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_ysyx_22040365_wbu.sv
// Directed bench for the writeback unit: reset, ALU writes, x0, back-to-back,
// load extraction, load latency, timeout and error reporting.
module tb_ysyx_22040365_wbu;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ysyx_22040365_wbu_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) bus ();

  ysyx_22040365_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic wen, input logic is_load,
                       input logic [2:0] f3, input logic [2:0] lo, input logic [63:0] res);
    bus.in_valid   = 1'b1;
    bus.in_rd      = rd;
    bus.in_rd_wen  = wen;
    bus.in_is_load = is_load;
    bus.in_funct3  = f3;
    bus.in_addr_lo = lo;
    bus.in_result  = res;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Single load into x9 with data returned the cycle after acceptance.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [2:0] lo,
                         input logic [63:0] rdata, input logic [63:0] expected);
    drive(5'd9, 1'b1, 1'b1, f3, lo, 64'hDEAD);
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    tick();
    bus.mem_rvalid = 1'b0;
    check({tag, "_commit"}, 64'(bus.commit_valid), 64'd1);
    check({tag, "_wdata"}, bus.rf_wdata, expected);
    tick();
  endtask

  initial begin
    int k;
    n_checks = 0;
    n_fail   = 0;
    bus.in_valid   = 1'b0;
    bus.in_rd      = '0;
    bus.in_rd_wen  = 1'b0;
    bus.in_is_load = 1'b0;
    bus.in_funct3  = '0;
    bus.in_addr_lo = '0;
    bus.in_result  = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    // Reset
    do_reset();
    check("rst_wen",    64'(bus.rf_wen), 64'd0);
    check("rst_waddr",  64'(bus.rf_waddr), 64'd0);
    check("rst_wdata",  bus.rf_wdata, 64'd0);
    check("rst_commit", 64'(bus.commit_valid), 64'd0);
    check("rst_err",    64'(bus.err), 64'd0);
    check("rst_ready",  64'(bus.in_ready), 64'd1);

    // ALU write to x5
    drive(5'd5, 1'b1, 1'b0, 3'd0, 3'd0, 64'h1234);
    tick();
    bus.in_valid = 1'b0;
    check("alu_commit", 64'(bus.commit_valid), 64'd1);
    check("alu_wen",    64'(bus.rf_wen), 64'd1);
    check("alu_waddr",  64'(bus.rf_waddr), 64'd5);
    check("alu_wdata",  bus.rf_wdata, 64'h1234);
    tick();
    check("idle_commit", 64'(bus.commit_valid), 64'd0);
    check("idle_wen",    64'(bus.rf_wen), 64'd0);
    check("idle_waddr_hold", 64'(bus.rf_waddr), 64'd5);
    check("idle_wdata_hold", bus.rf_wdata, 64'h1234);

    // x0 followed back-to-back by x7
    drive(5'd0, 1'b1, 1'b0, 3'd0, 3'd0, 64'hAAAA);
    tick();
    drive(5'd7, 1'b1, 1'b0, 3'd0, 3'd0, 64'h77);
    check("x0_commit", 64'(bus.commit_valid), 64'd1);
    check("x0_wen",    64'(bus.rf_wen), 64'd0);
    check("b2b_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("x7_commit", 64'(bus.commit_valid), 64'd1);
    check("x7_wen",    64'(bus.rf_wen), 64'd1);
    check("x7_waddr",  64'(bus.rf_waddr), 64'd7);
    check("x7_wdata",  bus.rf_wdata, 64'h77);
    tick();
    check("x7_done", 64'(bus.commit_valid), 64'd0);

    // Load extraction
    do_load("lh6",  3'b001, 3'd6, 64'h80FF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_80FF);
    do_load("lhu6", 3'b101, 3'd6, 64'h80FF_0000_0000_0000, 64'h0000_0000_0000_80FF);
    do_load("lb7",  3'b000, 3'd7, 64'h80FF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    do_load("lbu7", 3'b100, 3'd7, 64'h80FF_0000_0000_0000, 64'h0000_0000_0000_0080);
    do_load("lw4",  3'b010, 3'd4, 64'h80FF_0000_0000_0000, 64'hFFFF_FFFF_80FF_0000);
    do_load("lwu4", 3'b110, 3'd4, 64'h80FF_0000_0000_0000, 64'h0000_0000_80FF_0000);
    do_load("ld0",  3'b011, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    do_load("lb0",  3'b000, 3'd0, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFEF);
    do_load("lbu1", 3'b100, 3'd1, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_00CD);
    check("load_err_clear", 64'(bus.err), 64'd0);

    // Latency: rvalid three cycles after accept
    drive(5'd3, 1'b1, 1'b1, 3'b011, 3'd0, 64'h0);
    tick();
    bus.in_valid = 1'b0;
    check("lat_ready1",  64'(bus.in_ready), 64'd0);
    check("lat_commit1", 64'(bus.commit_valid), 64'd0);
    tick();
    check("lat_ready2",  64'(bus.in_ready), 64'd0);
    check("lat_commit2", 64'(bus.commit_valid), 64'd0);
    tick();
    check("lat_ready3",  64'(bus.in_ready), 64'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h1122_3344_5566_7788;
    tick();
    bus.mem_rvalid = 1'b0;
    check("lat_commit", 64'(bus.commit_valid), 64'd1);
    check("lat_waddr",  64'(bus.rf_waddr), 64'd3);
    check("lat_wdata",  bus.rf_wdata, 64'h1122_3344_5566_7788);
    check("lat_ready_w", 64'(bus.in_ready), 64'd1);
    tick();
    check("lat_done", 64'(bus.commit_valid), 64'd0);

    // Reserved funct3 commits zero and flags an error
    do_load("rsv", 3'b111, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    check("rsv_err", 64'(bus.err), 64'd1);

    // Timeout: no rvalid ever arrives
    do_reset();
    check("to_err_clear", 64'(bus.err), 64'd0);
    drive(5'd4, 1'b1, 1'b1, 3'b011, 3'd0, 64'h0);
    tick();
    bus.in_valid = 1'b0;
    k = 1;
    while (bus.commit_valid !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    check("to_cycles", 64'(k), 64'd256);
    check("to_commit", 64'(bus.commit_valid), 64'd1);
    check("to_wdata",  bus.rf_wdata, 64'd0);
    check("to_waddr",  64'(bus.rf_waddr), 64'd4);
    check("to_err",    64'(bus.err), 64'd1);
    tick();

    // rvalid on the final count: data wins, no error
    do_reset();
    drive(5'd6, 1'b1, 1'b1, 3'b011, 3'd0, 64'h0);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 254; i++) tick();
    check("edge_nocommit", 64'(bus.commit_valid), 64'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hCAFE_F00D_0000_0042;
    tick();
    bus.mem_rvalid = 1'b0;
    check("edge_commit", 64'(bus.commit_valid), 64'd1);
    check("edge_wdata",  bus.rf_wdata, 64'hCAFE_F00D_0000_0042);
    check("edge_err",    64'(bus.err), 64'd0);
    tick();

    // Reset aborts an in-flight load; its later rvalid is spurious
    drive(5'd8, 1'b1, 1'b1, 3'b011, 3'd0, 64'h0);
    tick();
    bus.in_valid = 1'b0;
    do_reset();
    check("abort_ready", 64'(bus.in_ready), 64'd1);
    check("abort_err0",  64'(bus.err), 64'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h5555;
    tick();
    bus.mem_rvalid = 1'b0;
    check("spur_err",    64'(bus.err), 64'd1);
    check("spur_commit", 64'(bus.commit_valid), 64'd0);
    check("spur_wdata",  bus.rf_wdata, 64'd0);
    tick();
    check("spur_sticky", 64'(bus.err), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
